// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer and memory-port arbiter (fetch vs. program loader).
// Define IMEM_FETCH_PERF_EN to add the Fetch_Count / Flush_Count performance counters.
module imem_fetch_ctrl #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                MEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_PC,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_PC,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    input  logic              Ld_Req,
    input  logic [ADDR_W-1:0] Ld_Addr,
    input  logic [DATA_W-1:0] Ld_Data,
    output logic              Ld_Ack,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Read,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] Mem_Data_In,
    input  logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Halted,
    output logic              Fault
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]       Fetch_Count,
    output logic [15:0]       Flush_Count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_HALT} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [DATA_W-1:0]   instr_nxt;
    logic [ADDR_W-1:0]   instr_pc_nxt;
    logic                valid_nxt, fault_nxt, ack_nxt;
    logic                pc_ok, ld_ok;

    assign pc_ok  = {1'b0, pc} < DEPTH;
    assign ld_ok  = {1'b0, Ld_Addr} < DEPTH;
    assign Halted = (state == S_HALT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            Instr       <= '0;
            Instr_PC    <= '0;
            Instr_Valid <= 1'b0;
            Ld_Ack      <= 1'b0;
            Fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            Instr       <= instr_nxt;
            Instr_PC    <= instr_pc_nxt;
            Instr_Valid <= valid_nxt;
            Ld_Ack      <= ack_nxt;
            Fault       <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = Instr;
        instr_pc_nxt = Instr_PC;
        valid_nxt    = Instr_Valid;
        fault_nxt    = Fault;
        ack_nxt      = 1'b0;
        Mem_Addr     = pc;
        Mem_Read     = 1'b0;
        Mem_Write    = 1'b0;
        Mem_Data_In  = '0;

        // A consumed instruction retires unless a new issue overwrites it below.
        if (Instr_Valid && Instr_Ready)
            valid_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (Ld_Req)   state_nxt = S_LOAD;
                else if (Run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (Redirect) begin
                    pc_nxt    = Redirect_PC;
                    valid_nxt = 1'b0;
                end else if ((!Instr_Valid || Instr_Ready) && Run) begin
                    if (pc_ok) begin
                        Mem_Read     = 1'b1;
                        instr_nxt    = Mem_Data_Out;
                        instr_pc_nxt = pc;
                        valid_nxt    = 1'b1;
                        pc_nxt       = pc + ADDR_W'(1);
                    end else begin
                        valid_nxt = 1'b0;
                        fault_nxt = 1'b1;
                        state_nxt = S_HALT;
                    end
                end else if (!Run && !Instr_Valid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (Ld_Req) begin
                    Mem_Addr    = Ld_Addr;
                    Mem_Data_In = Ld_Data;
                    Mem_Write   = ld_ok;
                    ack_nxt     = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                if (Ld_Req) begin
                    state_nxt = S_LOAD;
                end else if (!Run) begin
                    state_nxt = S_IDLE;
                    pc_nxt    = RESET_PC;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef IMEM_FETCH_PERF_EN
    logic flush;
    assign flush = (state == S_FETCH) && Redirect && Instr_Valid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Fetch_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (Mem_Read && (Fetch_Count != '1))
                Fetch_Count <= Fetch_Count + 32'd1;
            if (flush && (Flush_Count != '1))
                Flush_Count <= Flush_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a model memory image plus a next-PC model
// predict the fetched stream; loader writes are predicted through a write queue.
module tb_imem_fetch_ctrl;

    logic        Clk, Reset_n, Run, Redirect, Instr_Ready, Ld_Req;
    logic [15:0] Redirect_PC, Ld_Addr, Ld_Data;
    logic [15:0] Instr, Instr_PC, Mem_Addr, Mem_Data_In, Mem_Data_Out;
    logic        Instr_Valid, Ld_Ack, Mem_Read, Mem_Write, Halted, Fault;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_pc = 0;
    int          acks = 0;
    int          exp_acks = 0;
    logic [15:0] mem_model [64];
    logic [15:0] mem [64];
    logic [31:0] wq [$];
    logic [15:0] la [$];
    logic [15:0] ld [$];

    imem_fetch_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Redirect(Redirect),
        .Redirect_PC(Redirect_PC), .Instr(Instr), .Instr_PC(Instr_PC),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Ld_Req(Ld_Req),
        .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data), .Ld_Ack(Ld_Ack), .Mem_Addr(Mem_Addr),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Data_In(Mem_Data_In),
        .Mem_Data_Out(Mem_Data_Out), .Halted(Halted), .Fault(Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Physical instruction memory: combinational read, write on the clock edge.
    assign Mem_Data_Out = (Mem_Addr < 16'd64) ? mem[Mem_Addr[5:0]] : 16'h0000;
    always @(posedge Clk)
        if (Mem_Write && Mem_Addr < 16'd64) mem[Mem_Addr[5:0]] <= Mem_Data_In;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: consumes DUT activity and compares against the model.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Instr_Valid && Instr_Ready) begin
                chk("fetch_pc", 32'(Instr_PC), 32'(exp_pc));
                chk("fetch_data", 32'(Instr), (exp_pc < 64) ? 32'(mem_model[exp_pc]) : 32'd0);
                exp_pc++;
            end
            if (Mem_Write) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(Mem_Addr), 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] w;
                    w = wq.pop_front();
                    chk("wr_addr", 32'(Mem_Addr), 32'(w[31:16]));
                    chk("wr_data", 32'(Mem_Data_In), 32'(w[15:0]));
                end
            end
            if (Mem_Read || Mem_Write)
                chk("rd_wr_excl", 32'(Mem_Read & Mem_Write), 32'd0);
            if (Mem_Read)
                chk("rd_in_range", 32'(Mem_Addr < 16'd64), 32'd1);
            if (Ld_Ack) acks++;
        end
    end

    task automatic reset_check(input string tag);
        chk({tag, ".instr"}, 32'(Instr), 32'd0);
        chk({tag, ".instr_pc"}, 32'(Instr_PC), 32'd0);
        chk({tag, ".flags"}, 32'({Instr_Valid, Ld_Ack, Halted, Fault, Mem_Read, Mem_Write}), 32'd0);
        chk({tag, ".mem_addr"}, 32'(Mem_Addr), 32'd0);
        chk({tag, ".mem_din"}, 32'(Mem_Data_In), 32'd0);
    endtask

    // Loader burst from IDLE/HALT: one transition cycle, then one write per cycle.
    task automatic load_burst();
        Ld_Req = 1'b1; Ld_Addr = la[0]; Ld_Data = ld[0];
        step();
        foreach (la[i]) begin
            Ld_Addr = la[i]; Ld_Data = ld[i];
            if (la[i] < 16'd64) begin
                wq.push_back({la[i], ld[i]});
                mem_model[la[i][5:0]] = ld[i];
            end
            exp_acks++;
            step();
        end
        Ld_Req = 1'b0;
        step();
        step();
        chk("ld_ack_count", 32'(acks), 32'(exp_acks));
        chk("ld_writes_left", 32'(wq.size()), 32'd0);
        la.delete();
        ld.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0; Run = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
        Instr_Ready = 1'b0; Ld_Req = 1'b0; Ld_Addr = '0; Ld_Data = '0;
        #12;
        reset_check("por");
        Reset_n = 1'b1;
        step();

        // Fill the whole memory through the loader; words 0..3 are the known program.
        for (int i = 0; i < 64; i++) begin
            la.push_back(16'(i));
            case (i)
                0:       ld.push_back(16'h8000);
                1:       ld.push_back(16'h8111);
                2:       ld.push_back(16'h2012);
                3:       ld.push_back(16'h8331);
                default: ld.push_back(16'($urandom));
            endcase
        end
        load_burst();

        // Start fetching: one cycle to enter FETCH, one to issue, then valid.
        exp_pc = 0; Run = 1'b1; Instr_Ready = 1'b1;
        @(negedge Clk); chk("lat_c0_valid", 32'(Instr_Valid), 32'd0); step();
        @(negedge Clk); chk("lat_c1_valid", 32'(Instr_Valid), 32'd0); step();
        @(negedge Clk); chk("lat_c2_valid", 32'(Instr_Valid), 32'd1);
        chk("lat_c2_instr", 32'(Instr), 32'h8000); step();

        // Backpressure while Instr_PC=1.
        Instr_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("bp_instr", 32'(Instr), 32'h8111);
            chk("bp_instr_pc", 32'(Instr_PC), 32'd1);
            chk("bp_mem_read", 32'(Mem_Read), 32'd0);
            chk("bp_pc_held", 32'(Mem_Addr), 32'd2);
            step();
        end
        Instr_Ready = 1'b1;
        step();
        @(negedge Clk); chk("bp_release_pc", 32'(Instr_PC), 32'd2);
        step();

        // Redirect to 7 while PC 8 is presented and not accepted.
        for (int k = 0; k < 20; k++) begin
            if (Instr_Valid && Instr_PC == 16'd8) break;
            step();
        end
        chk("reach_pc8", 32'(Instr_Valid && Instr_PC == 16'd8), 32'd1);
        Instr_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 16'd7; exp_pc = 7;
        step();
        Redirect = 1'b0; Instr_Ready = 1'b1;
        @(negedge Clk); chk("redir_flush_valid", 32'(Instr_Valid), 32'd0); step();
        @(negedge Clk); chk("redir_target_valid", 32'(Instr_Valid), 32'd1);
        chk("redir_target_pc", 32'(Instr_PC), 32'd7); step();

        // Pause and resume: the stream must continue in order.
        Run = 1'b0;
        repeat (4) step();
        chk("pause_not_halted", 32'(Halted), 32'd0);
        Run = 1'b1;
        repeat (6) step();

        // Randomized backpressure and redirects, kept below the end of memory.
        for (int c = 0; c < 400; c++) begin
            if (exp_pc >= 50 || $urandom_range(0, 7) == 0) begin
                Redirect = 1'b1;
                Redirect_PC = 16'($urandom_range(0, 40));
                exp_pc = int'(Redirect_PC);
                Instr_Ready = 1'b0;
            end else begin
                Redirect = 1'b0;
                Instr_Ready = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        Redirect = 1'b0;

        // Run off the end of memory.
        Instr_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 16'd60; exp_pc = 60;
        step();
        Redirect = 1'b0; Instr_Ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (Halted) break;
            step();
        end
        @(negedge Clk);
        chk("oor_halted", 32'(Halted), 32'd1);
        chk("oor_fault", 32'(Fault), 32'd1);
        chk("oor_valid", 32'(Instr_Valid), 32'd0);
        chk("oor_delivered_to", 32'(exp_pc), 32'd64);
        step();
        Run = 1'b0;
        step();
        @(negedge Clk);
        chk("halt_exit_halted", 32'(Halted), 32'd0);
        chk("halt_exit_fault", 32'(Fault), 32'd1);
        chk("halt_exit_pc", 32'(Mem_Addr), 32'd0);
        step();

        // Loader with one out-of-range address, then fetch from the new words.
        la.push_back(16'd5);  ld.push_back(16'hA616);
        la.push_back(16'd6);  ld.push_back(16'hA737);
        la.push_back(16'd70); ld.push_back(16'hFFFF);
        load_burst();
        chk("load_fault_sticky", 32'(Fault), 32'd1);
        Run = 1'b1; Instr_Ready = 1'b0;
        step();
        Redirect = 1'b1; Redirect_PC = 16'd5; exp_pc = 5;
        step();
        Redirect = 1'b0; Instr_Ready = 1'b1;
        step();
        @(negedge Clk);
        chk("load_fetch_pc", 32'(Instr_PC), 32'd5);
        chk("load_fetch_data", 32'(Instr), 32'hA616);
        repeat (3) step();

        // Reset in the middle of fetching.
        #2 Reset_n = 1'b0;
        #1 reset_check("rst_fetch");
        Run = 1'b0;
        exp_pc = 0;
        step();
        Reset_n = 1'b1;
        step();

        // Reset in the middle of a load: the write must not land.
        Ld_Req = 1'b1; Ld_Addr = 16'd10; Ld_Data = 16'hDEAD;
        step();
        #2 Reset_n = 1'b0;
        #1 reset_check("rst_load");
        Ld_Req = 1'b0;
        step();
        Reset_n = 1'b1;
        step();

        // Fetch 0.. again to confirm memory contents after the aborted load.
        exp_pc = 0; Run = 1'b1; Instr_Ready = 1'b1;
        repeat (16) step();
        chk("final_progress", 32'(exp_pc > 10), 32'd1);
        chk("final_ack_count", 32'(acks), 32'(exp_acks));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
